// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  localparam int              XLEN     = 32;
  localparam logic [XLEN-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    BOOT,
    FETCH
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO used for the fetch entry queue and the request address tags.
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  logic [WIDTH-1:0] mem [DEPTH];
  ptr_t             wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  // A push onto a full queue is accepted only when a pop frees the head slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (count == cnt_t'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
      if (do_push && !do_pop)      count <= count + cnt_t'(1);
      else if (!do_push && do_pop) count <= count - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited imem reads, queues words for IF/ID.
// Define IF_BYPASS_EN to forward a response straight onto id_* when the queue is empty.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = fetch_pkg::XLEN,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_npc,
  output logic [XLEN-1:0] id_instr
);

  localparam int CW = $clog2(DEPTH) + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   sum_t;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] pc, tag_head;
  cnt_t            q_count, inflight, inflight_next, drop;
  sum_t            occupancy;
  logic            q_empty, q_full, tag_empty, tag_full, unused_q_full;
  logic            credit, req_fire, rsp_ok, push, pop, bypass_take;
  fetch_entry_t    q_head, q_wdata, id_entry;

  // The tag FIFO holds one address per outstanding request, so its count is the inflight count.
  assign occupancy     = sum_t'(q_count) + sum_t'(inflight);
  assign credit        = !tag_full && (occupancy < sum_t'(DEPTH));
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign rsp_ok        = imem_rsp_valid && !tag_empty;
  assign imem_req_addr = pc;
  assign q_wdata       = '{pc: tag_head, instr: imem_rsp_data};
  assign pop           = id_ready && !q_empty;
  assign push          = rsp_ok && (drop == '0) && !redirect_valid && !bypass_take;
  assign unused_q_full = q_full;

  always_comb begin
    inflight_next = inflight;
    if (req_fire && !rsp_ok)      inflight_next = inflight + cnt_t'(1);
    else if (!req_fire && rsp_ok) inflight_next = inflight - cnt_t'(1);
  end

  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    case (state)
      BOOT:  state_next     = FETCH;
      FETCH: imem_req_valid = credit;
    endcase
  end

  // A redirect retires everything still outstanding into drop, including a request accepted now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      pc    <= RESET_PC;
      drop  <= '0;
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        pc   <= redirect_pc;
        drop <= inflight_next;
      end else begin
        if (req_fire) pc <= pc + XLEN'(1);
        if (rsp_ok && (drop != '0)) drop <= drop - cnt_t'(1);
      end
    end
  end

`ifdef IF_BYPASS_EN
  logic bypass;
  assign bypass      = q_empty && rsp_ok && (drop == '0) && !redirect_valid;
  assign bypass_take = bypass && id_ready;
  assign id_valid    = !q_empty || bypass;
  always_comb begin
    id_entry = '0;
    if (!q_empty)    id_entry = q_head;
    else if (bypass) id_entry = q_wdata;
  end
`else
  assign bypass_take = 1'b0;
  assign id_valid    = !q_empty;
  assign id_entry    = q_empty ? '0 : q_head;
`endif

  assign id_pc    = id_entry.pc;
  assign id_npc   = id_valid ? id_entry.pc + XLEN'(1) : '0;
  assign id_instr = id_entry.instr;

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_entry_q (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_tag_q (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .pop   (rsp_ok),
    .flush (1'b0),
    .wdata (pc),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (inflight)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases, in-order memory model, decoupled id monitor.
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_pc, id_npc, id_instr;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  bit          stall = 1'b1;
  int          mem_lat = 1;
  int          edge_cnt = 0;
  int          fire_cnt = 0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] exp_req_addr = RST_PC;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_pc          (id_pc),
    .id_npc         (id_npc),
    .id_instr       (id_instr)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One-cycle redirect pulse; called and returns at 1 time unit after a rising edge.
  task automatic applyStimulus(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    waitCycles(1);
    redirect_valid = 1'b0;
  endtask

  task automatic expectRange(input logic [31:0] first, input int n);
    logic [31:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(a);
      a = a + 32'd1;
    end
  endtask

  task automatic waitDrain(input string name, input int limit);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < limit) begin
      waitCycles(1);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drain remaining=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    waitCycles(1);
  endtask

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // id_ready only accepts while the scoreboard still expects entries.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      id_ready = !stall && (exp_q.size() > 0);
    end
  end

  // In-order memory model: checks request addresses and returns instr_of(addr) after mem_lat edges.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        exp_req_addr   = RST_PC;
      end else begin
        imem_rsp_valid = 1'b0;
        if (pend_due.size() > 0 && pend_due[0] == edge_cnt + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = instr_of(pend_addr[0]);
          void'(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end
        if (imem_req_valid && imem_req_ready) begin
          checkOutput("imem_req_addr", imem_req_addr, exp_req_addr);
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(edge_cnt + 1 + mem_lat);
          fire_cnt++;
          exp_req_addr = exp_req_addr + 32'd1;
        end
        if (redirect_valid) exp_req_addr = redirect_pc;
      end
    end
  end

  // Monitor: every IF/ID handshake pops one expected pc from the scoreboard.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL id_unexpected actual_pc=0x%08h expected=none", id_pc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("id_pc", id_pc, e);
          checkOutput("id_npc", id_npc, e + 32'd1);
          checkOutput("id_instr", id_instr, instr_of(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values and BOOT cycle
    waitCycles(3);
    checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("rst_req_addr", imem_req_addr, RST_PC);
    checkOutput("rst_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("rst_id_pc", id_pc, 32'h0);
    checkOutput("rst_id_npc", id_npc, 32'h0);
    checkOutput("rst_id_instr", id_instr, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("boot_req_valid", {31'b0, imem_req_valid}, 32'h0);
    waitCycles(1);
    checkOutput("fetch_req_valid", {31'b0, imem_req_valid}, 32'h1);
    checkOutput("fetch_req_addr", imem_req_addr, 32'h10);

    // Sequential fetch from RESET_PC, latency 1
    expectRange(32'h10, 8);
    stall = 1'b0;
    waitDrain("seq", 60);

    // ID stall: credit limits to DEPTH requests
    stall = 1'b1;
    waitCycles(8);
    applyStimulus(32'h20);
    begin
      int f0;
      f0 = fire_cnt;
      waitCycles(10);
      checkOutput("stall_req_count", fire_cnt - f0, 32'd4);
    end
    checkOutput("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("stall_id_valid", {31'b0, id_valid}, 32'h1);
    expectRange(32'h20, 4);
    stall = 1'b0;
    waitDrain("stall", 40);

    // Redirect with three fetches in flight, latency 3
    stall = 1'b1;
    waitCycles(8);
    mem_lat = 3;
    applyStimulus(32'h30);
    waitCycles(2);
    applyStimulus(32'h40);
    checkOutput("redir_id_valid", {31'b0, id_valid}, 32'h0);
    expectRange(32'h40, 6);
    stall = 1'b0;
    waitDrain("redirect", 80);

    // PC wrap at the top of the address space
    stall = 1'b1;
    waitCycles(10);
    mem_lat = 1;
    applyStimulus(32'hFFFF_FFFE);
    expectRange(32'hFFFF_FFFE, 4);
    stall = 1'b0;
    waitDrain("wrap", 40);

    // Memory backpressure holds the request address
    stall = 1'b1;
    waitCycles(8);
    imem_req_ready = 1'b0;
    applyStimulus(32'h50);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold_req_valid", {31'b0, imem_req_valid}, 32'h1);
      checkOutput("hold_req_addr", imem_req_addr, 32'h50);
      waitCycles(1);
    end
    imem_req_ready = 1'b1;
    expectRange(32'h50, 6);
    stall = 1'b0;
    waitDrain("hold", 40);

    // Asynchronous reset with two requests outstanding
    stall = 1'b1;
    waitCycles(8);
    mem_lat = 3;
    applyStimulus(32'h60);
    waitCycles(2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    checkOutput("arst_req_addr", imem_req_addr, RST_PC);
    checkOutput("arst_id_valid", {31'b0, id_valid}, 32'h0);
    checkOutput("arst_id_pc", id_pc, 32'h0);
    checkOutput("arst_id_npc", id_npc, 32'h0);
    checkOutput("arst_id_instr", id_instr, 32'h0);
    waitCycles(2);
    mem_lat = 1;
    rst = 1'b0;
    expectRange(RST_PC, 4);
    stall = 1'b0;
    waitDrain("post_rst", 40);

    stall = 1'b1;
    waitCycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
